// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: pixel/line counters, active-video flag,
// line/frame pulses, and active-low sync outputs delayed to match the color pipeline.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter int unsigned SYNC_DELAY = 2
) (
   input  logic       vga_clk,
   input  logic       reset,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       line_start,
   output logic       frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0] hc_q, hc_d;
   logic [9:0] vc_q, vc_d;
   logic       blank_q, blank_d;
   logic       ls_q, ls_d;
   logic       fs_q, fs_d;
   logic       hs_raw_q, hs_raw_d;
   logic       vs_raw_q, vs_raw_d;
   logic       h_wrap;
   logic [10:0] hx, vy;

   // Flags decode the next-state counters so they land on the same edge as DrawX/DrawY.
   always_comb begin
      h_wrap = (hc_q == H_LAST);
      hc_d   = h_wrap ? '0 : hc_q + 10'd1;
      vc_d   = vc_q;
      if (h_wrap) begin
         vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
      end
      hx       = {1'b0, hc_d};
      vy       = {1'b0, vc_d};
      blank_d  = (hx < H_ACT) && (vy < V_ACT);
      hs_raw_d = !((hx >= HS_START) && (hx < HS_END));
      vs_raw_d = !((vy >= VS_START) && (vy < VS_END));
      ls_d     = (hc_d == '0);
      fs_d     = (hc_d == '0) && (vc_d == '0);
   end

   // Reset parks the counters on the last pixel so the first free-running edge is (0,0).
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         hc_q     <= H_LAST;
         vc_q     <= V_LAST;
         blank_q  <= 1'b0;
         ls_q     <= 1'b0;
         fs_q     <= 1'b0;
         hs_raw_q <= 1'b1;
         vs_raw_q <= 1'b1;
      end else begin
         hc_q     <= hc_d;
         vc_q     <= vc_d;
         blank_q  <= blank_d;
         ls_q     <= ls_d;
         fs_q     <= fs_d;
         hs_raw_q <= hs_raw_d;
         vs_raw_q <= vs_raw_d;
      end
   end

   assign DrawX       = hc_q;
   assign DrawY       = vc_q;
   assign blank       = blank_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;

   generate
      if (SYNC_DELAY == 0) begin : g_nodly
         assign hs = hs_raw_q;
         assign vs = vs_raw_q;
      end else begin : g_dly
         logic [SYNC_DELAY-1:0] hs_sr_q;
         logic [SYNC_DELAY-1:0] vs_sr_q;

         // Stages flush to the inactive level so a reset never leaves a partial pulse.
         always_ff @(posedge vga_clk) begin
            if (reset) begin
               hs_sr_q <= '1;
               vs_sr_q <= '1;
            end else begin
               hs_sr_q[0] <= hs_raw_q;
               vs_sr_q[0] <= vs_raw_q;
               for (int unsigned i = 1; i < SYNC_DELAY; i++) begin
                  hs_sr_q[i] <= hs_sr_q[i-1];
                  vs_sr_q[i] <= vs_sr_q[i-1];
               end
            end
         end

         assign hs = hs_sr_q[SYNC_DELAY-1];
         assign vs = vs_sr_q[SYNC_DELAY-1];
      end
   endgenerate

endmodule
